// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access stage.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   // Reserved size 11 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_formatter
   import mem_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        ext_bit;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'b01:   byte_lane = rdata[15:8];
         2'b10:   byte_lane = rdata[23:16];
         2'b11:   byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      ext_bit   = 1'b0;
      data      = rdata;
      case (size)
         SZ_BYTE: begin
            ext_bit = ~is_unsigned & byte_lane[7];
            data    = {{24{ext_bit}}, byte_lane};
         end
         SZ_HALF: begin
            ext_bit = ~is_unsigned & half_lane[15];
            data    = {{16{ext_bit}}, half_lane};
         end
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues one outstanding data-memory transaction per load/store,
// stalls the pipeline until it completes, and formats load data for MEM/WB.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   alu_result_in,
   input  logic [XLEN-1:0]   store_data_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic [1:0]        size_in,
   input  logic              unsigned_in,
   input  logic              dmem_ready,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [BE_W-1:0]   dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [XLEN-1:0]   mem_data_out,
   output logic              stall_out,
   output logic              misalign_err_out,
   output logic              bus_err_out
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   mdata_q, mdata_d;
   logic              bus_err_q, bus_err_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;

   logic              mem_op;
   logic              misaligned;
   logic [XLEN-1:0]   load_data;

   assign mem_op     = MemRead_in | MemWrite_in;
   assign misaligned = is_misaligned(size_in, alu_result_in[1:0]);

   load_formatter u_load_formatter (
      .rdata       (dmem_rdata),
      .addr_lo     (addr_lo_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .data        (load_data)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      mdata_d   = mdata_q;
      bus_err_d = 1'b0;
      addr_lo_d = addr_lo_q;
      size_d    = size_q;
      uns_d     = uns_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_op && misaligned) begin
               mdata_d = '0;
            end else if (mem_op) begin
               state_d   = ST_ACCESS;
               cnt_d     = '0;
               req_d     = 1'b1;
               we_d      = MemWrite_in;
               addr_d    = {alu_result_in[XLEN-1:2], 2'b00};
               addr_lo_d = alu_result_in[1:0];
               size_d    = size_in;
               uns_d     = unsigned_in;
               be_d      = 4'b1111;
               wdata_d   = '0;
               if (MemWrite_in) begin
                  case (size_in)
                     SZ_BYTE: begin
                        be_d    = 4'b0001 << alu_result_in[1:0];
                        wdata_d = {4{store_data_in[7:0]}};
                     end
                     SZ_HALF: begin
                        be_d    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{store_data_in[15:0]}};
                     end
                     default: wdata_d = store_data_in;
                  endcase
               end
            end
         end
         ST_ACCESS: begin
            if (dmem_ready) begin
               if (!we_q) begin
                  mdata_d = load_data;
               end
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (cnt_q == TO_LAST) begin
               req_d     = 1'b0;
               mdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         mdata_q   <= '0;
         bus_err_q <= 1'b0;
         addr_lo_q <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         mdata_q   <= mdata_d;
         bus_err_q <= bus_err_d;
         addr_lo_q <= addr_lo_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
      end
   end

   // Stall and misalign flags are combinational so the hold takes effect this cycle.
   assign stall_out        = rst_n & (((state_q == ST_IDLE) & mem_op & ~misaligned) |
                                      (state_q == ST_ACCESS));
   assign misalign_err_out = rst_n & (state_q == ST_IDLE) & mem_op & misaligned;

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign mem_data_out = mdata_q;
   assign bus_err_out  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: randomized loads/stores against a reference model.
module tb_mem_access_unit;

   localparam int unsigned TO = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu_result_in, store_data_in, dmem_rdata;
   logic        MemRead_in, MemWrite_in, unsigned_in, dmem_ready;
   logic [1:0]  size_in;
   logic        dmem_req, dmem_we, stall_out, misalign_err_out, bus_err_out;
   logic [31:0] dmem_addr, dmem_wdata, mem_data_out;
   logic [3:0]  dmem_be;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .size_in(size_in), .unsigned_in(unsigned_in),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .mem_data_out(mem_data_out),
      .stall_out(stall_out), .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_req_t;

   typedef struct {
      logic [31:0] mdata;
      logic        bus_err;
      int          stall;
   } exp_done_t;

   exp_req_t  req_q[$];
   exp_done_t done_q[$];
   int        mis_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_mdata = '0;

   int          resp_wait  = 0;
   logic [31:0] resp_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, written from the access rules with plain arithmetic.
   function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
      int unsigned off = a % 4;
      if (sz == 2'd1) return (off % 2) != 0;
      if (sz >= 2'd2) return off != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
      int unsigned off = a % 4;
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (rd >> (8 * off)) % 256;
         if (!u && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (rd >> (16 * (off / 2))) % 65536;
         if (!u && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic exp_req_t ref_req(input logic wr, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] sz);
      exp_req_t r;
      int unsigned off = a % 4;
      r.we    = wr;
      r.addr  = a - off;
      r.be    = 4'hF;
      r.wdata = 32'h0;
      if (wr) begin
         if (sz == 2'd0) begin
            r.be    = 4'(1 << off);
            r.wdata = (d % 256) * 32'h01010101;
         end else if (sz == 2'd1) begin
            r.be    = (off >= 2) ? 4'hC : 4'h3;
            r.wdata = (d % 65536) * 32'h00010001;
         end else begin
            r.wdata = d;
         end
      end
      return r;
   endfunction

   // Memory responder: answers after resp_wait wait states; random noise on ready while idle.
   always @(posedge clk) begin
      #1;
      if (dmem_req) begin
         if (resp_wait == 0) begin
            dmem_ready = 1'b1;
            dmem_rdata = resp_rdata;
         end else begin
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            resp_wait--;
         end
      end else begin
         dmem_ready = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a request, completion or error.
   logic req_prev   = 1'b0;
   logic mdata_chk  = 1'b0;
   int   stall_run  = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         req_q.delete();
         done_q.delete();
         mis_cnt   = 0;
         req_prev  = 1'b0;
         mdata_chk = 1'b0;
         stall_run = 0;
      end else begin
         if (mdata_chk) begin
            check("misalign_mdata", mem_data_out, 32'h0);
            mdata_chk = 1'b0;
         end
         if (misalign_err_out) begin
            if (mis_cnt == 0) check("unexpected_misalign", 32'd1, 32'd0);
            else begin
               mis_cnt--;
               check("misalign_stall", 32'(stall_out), 32'd0);
               check("misalign_req", 32'(dmem_req), 32'd0);
               mdata_chk = 1'b1;
            end
         end
         if (dmem_req && !req_prev) begin
            if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
            else begin
               exp_req_t e;
               e = req_q.pop_front();
               check("req_we", 32'(dmem_we), 32'(e.we));
               check("req_addr", dmem_addr, e.addr);
               check("req_be", 32'(dmem_be), 32'(e.be));
               if (e.we) check("req_wdata", dmem_wdata, e.wdata);
            end
         end
         if (!dmem_req && req_prev) begin
            if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
               exp_done_t e;
               e = done_q.pop_front();
               check("done_mdata", mem_data_out, e.mdata);
               check("done_bus_err", 32'(bus_err_out), 32'(e.bus_err));
               check("done_stall", 32'(stall_out), 32'd0);
               check("stall_cycles", 32'(stall_run), 32'(e.stall));
            end
         end else if (bus_err_out) begin
            check("stray_bus_err", 32'd1, 32'd0);
         end
         stall_run = stall_out ? stall_run + 1 : 0;
         req_prev  = dmem_req;
      end
   end

   task automatic set_inputs(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] sz, input logic u);
      MemRead_in    = rd;
      MemWrite_in   = wr;
      alu_result_in = a;
      store_data_in = d;
      size_in       = sz;
      unsigned_in   = u;
   endtask

   // Issues one op starting in IDLE and returns in the IDLE cycle after it completes.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input logic [31:0] rdata, input int waits);
      exp_done_t dn;
      logic      seen = 1'b0;
      logic      fin  = 1'b0;
      logic      tmo;
      set_inputs(rd, wr, a, d, sz, u);
      if (!rd && !wr) begin
         @(posedge clk); #1;
         return;
      end
      if (ref_misaligned(a, sz)) begin
         mis_cnt++;
         model_mdata = 32'h0;
         @(posedge clk); #1;
         return;
      end
      req_q.push_back(ref_req(wr, a, d, sz));
      resp_wait  = waits;
      resp_rdata = rdata;
      tmo = (waits >= int'(TO));
      if (tmo) model_mdata = 32'h0;
      else if (!wr) model_mdata = ref_load(rdata, a, sz, u);
      dn.mdata   = model_mdata;
      dn.bus_err = tmo;
      dn.stall   = tmo ? int'(TO) + 1 : waits + 2;
      done_q.push_back(dn);
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (dmem_req) seen = 1'b1;
         else if (seen) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) check("txn_bound", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle_cycles(input int n);
      set_inputs(1'b0, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle_hold_mdata", mem_data_out, model_mdata);
         check("idle_stall", 32'(stall_out), 32'd0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      dmem_ready  = 1'b0;
      dmem_rdata  = '0;
      mis_cnt     = 0;
      set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      #3;
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(stall_out), 32'd0);
      check("rst_mdata", mem_data_out, 32'h0);
      check("rst_misc", {dmem_addr[31:8], dmem_be, 1'b0, dmem_we, misalign_err_out, bus_err_out},
            32'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      issue(1, 0, 32'h100, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);
      check("lw_data", mem_data_out, 32'hDEADBEEF);
      issue(1, 0, 32'h103, 32'h0, 2'd0, 0, 32'h80FF0000, 1);
      check("lb_data", mem_data_out, 32'hFFFFFF80);
      issue(1, 0, 32'h103, 32'h0, 2'd0, 1, 32'h80FF0000, 0);
      check("lbu_data", mem_data_out, 32'h00000080);
      issue(0, 1, 32'h202, 32'h1234ABCD, 2'd1, 0, 32'h0, 2);
      check("sh_mdata_kept", mem_data_out, 32'h00000080);
      issue(1, 0, 32'h101, 32'h0, 2'd2, 0, 32'h0, 0);
      check("mis_lw_mdata", mem_data_out, 32'h0);
      issue(1, 0, 32'h104, 32'h0, 2'd2, 0, 32'h55AA55AA, 0);
      issue(1, 0, 32'h108, 32'h0, 2'd2, 0, 32'h11111111, TO + 4);
      check("timeout_mdata", mem_data_out, 32'h0);
      issue(1, 0, 32'h10C, 32'h0, 2'd1, 0, 32'h7FFF1234, TO - 1);
      check("ready_at_timeout", mem_data_out, 32'h00001234);
      issue(1, 1, 32'h300, 32'h0BADF00D, 2'd3, 0, 32'h0, 0);
      idle_cycles(3);

      // Reset three wait cycles into a store.
      set_inputs(0, 1, 32'h400, 32'hCAFEF00D, 2'd2, 0);
      req_q.push_back(ref_req(1'b1, 32'h400, 32'hCAFEF00D, 2'd2));
      resp_wait = 100;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_req", 32'(dmem_req), 32'd0);
      check("arst_stall", 32'(stall_out), 32'd0);
      check("arst_outs", dmem_addr | dmem_wdata | mem_data_out | 32'(dmem_be), 32'h0);
      check("arst_flags", {29'd0, dmem_we, misalign_err_out, bus_err_out}, 32'h0);
      set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      model_mdata = 32'h0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1, 0, 32'h500, 32'h0, 2'd2, 0, 32'h13579BDF, 1);
      check("post_rst_lw", mem_data_out, 32'h13579BDF);

      // Randomized traffic, back-to-back with occasional idle gaps.
      for (int n = 0; n < 250; n++) begin
         logic [1:0]  op;
         logic [31:0] a;
         int          w;
         op = 2'($urandom_range(1, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         case ($urandom_range(0, 9))
            0:       w = int'(TO) - 1;
            1:       w = int'(TO) + int'($urandom_range(0, 3));
            default: w = int'($urandom_range(0, 4));
         endcase
         issue(op[0], op[1], a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, w);
         if ($urandom_range(0, 4) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end
      idle_cycles(2);
      check("queues_drained", 32'(req_q.size() + done_q.size() + mis_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
